// File: rtl/inner_loop_cs_param_if.sv
// Handshake and operand/result bundle for the carry-save inner-loop multiplier.
// INNER_LOOP_ACC_EN adds the acc operand.
interface inner_loop_cs_param_if #(
    parameter int unsigned LIMB_W    = 64,
    parameter int unsigned NUM_LIMBS = 48,
    parameter int unsigned EXT_W     = 2
);
    localparam int unsigned NW = NUM_LIMBS * LIMB_W;
    localparam int unsigned AW = NW + EXT_W;
    localparam int unsigned RW = NW + LIMB_W + EXT_W;

    logic              start;
    logic [AW-1:0]     a;
    logic [LIMB_W-1:0] bi;
`ifdef INNER_LOOP_ACC_EN
    logic [NW-1:0]     acc;
`endif
    logic              busy;
    logic              done;
    logic [RW-1:0]     r0;
    logic [RW-1:0]     r1;

    modport master (
        output start, a, bi,
`ifdef INNER_LOOP_ACC_EN
        output acc,
`endif
        input  busy, done, r0, r1
    );

    modport slave (
        input  start, a, bi,
`ifdef INNER_LOOP_ACC_EN
        input  acc,
`endif
        output busy, done, r0, r1
    );
endinterface

// File: rtl/inner_loop_cs_param.sv
// Multi-limb x single-word multiplier producing a*bi (+acc with INNER_LOOP_ACC_EN)
// in carry-save form r0 + r1, LANES limbs per cycle, multiply and write-back registered.
module inner_loop_cs_param #(
    parameter int unsigned LIMB_W    = 64,
    parameter int unsigned NUM_LIMBS = 48,
    parameter int unsigned LANES     = 16,
    parameter int unsigned EXT_W     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inner_loop_cs_param_if.slave bus
);
    localparam int unsigned NW     = NUM_LIMBS * LIMB_W;
    localparam int unsigned AW     = NW + EXT_W;
    localparam int unsigned RW     = NW + LIMB_W + EXT_W;
    localparam int unsigned PW     = 2 * LIMB_W;
    localparam int unsigned XW     = LIMB_W + EXT_W;
    localparam int unsigned ROUNDS = NUM_LIMBS / LANES;
    localparam int unsigned GW     = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
    localparam int unsigned AIW    = $clog2(AW);
    localparam int unsigned RIW    = $clog2(RW);

    if ((NUM_LIMBS % LANES) != 0) begin : g_bad_lanes
        $error("inner_loop_cs_param: NUM_LIMBS must be a multiple of LANES");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e            state_q, state_d;
    logic [GW-1:0]     g_q, g_d;
    logic [GW-1:0]     pg_q, pg_d;
    logic              pv_q, pv_d;
    logic [AW-1:0]     a_q, a_d;
    logic [LIMB_W-1:0] bi_q, bi_d;
    logic [PW-1:0]     prod_q [LANES];
    logic [PW-1:0]     prod_d [LANES];
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [RW-1:0]     r0_q, r0_d;
    logic [RW-1:0]     r1_q, r1_d;
    logic [AIW-1:0]    a_idx;
    logic [RIW-1:0]    lo_idx, hi_idx;
`ifdef INNER_LOOP_ACC_EN
    localparam int unsigned NIW = $clog2(NW);
    logic [NW-1:0]     acc_q, acc_d;
    logic [NIW-1:0]    c_idx;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            g_q     <= '0;
            pg_q    <= '0;
            pv_q    <= 1'b0;
            a_q     <= '0;
            bi_q    <= '0;
            prod_q  <= '{default: '0};
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            r0_q    <= '0;
            r1_q    <= '0;
`ifdef INNER_LOOP_ACC_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            pg_q    <= pg_d;
            pv_q    <= pv_d;
            a_q     <= a_d;
            bi_q    <= bi_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            r0_q    <= r0_d;
            r1_q    <= r1_d;
`ifdef INNER_LOOP_ACC_EN
            acc_q   <= acc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        pg_d    = pg_q;
        pv_d    = 1'b0;
        a_d     = a_q;
        bi_d    = bi_q;
        prod_d  = prod_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        r0_d    = r0_q;
        r1_d    = r1_q;
        a_idx   = '0;
        lo_idx  = '0;
        hi_idx  = '0;
`ifdef INNER_LOOP_ACC_EN
        acc_d   = acc_q;
        c_idx   = '0;
`endif

        // Write back the group multiplied in the previous cycle: low half at limb k, high at k+1.
        if (pv_q) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                lo_idx = RIW'((32'(pg_q) * LANES + i) * LIMB_W);
                hi_idx = RIW'((32'(pg_q) * LANES + i + 1) * LIMB_W);
                r0_d[lo_idx +: LIMB_W] = prod_q[i][LIMB_W-1:0];
                r1_d[hi_idx +: LIMB_W] = prod_q[i][PW-1:LIMB_W];
            end
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    bi_d    = bus.bi;
`ifdef INNER_LOOP_ACC_EN
                    acc_d   = bus.acc;
`endif
                    r0_d    = '0;
                    r1_d    = '0;
                    busy_d  = 1'b1;
                    g_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int unsigned i = 0; i < LANES; i++) begin
                    a_idx     = AIW'((32'(g_q) * LANES + i) * LIMB_W);
                    prod_d[i] = PW'(a_q[a_idx +: LIMB_W]) * PW'(bi_q);
`ifdef INNER_LOOP_ACC_EN
                    c_idx     = NIW'((32'(g_q) * LANES + i) * LIMB_W);
                    prod_d[i] = prod_d[i] + PW'(acc_q[c_idx +: LIMB_W]);
`endif
                end
                pv_d = 1'b1;
                pg_d = g_q;
                // Extension bits of a contribute one narrow product, written once.
                if (g_q == '0) begin
                    r0_d[NW +: XW] = XW'(a_q[NW +: EXT_W]) * XW'(bi_q);
                end
                if (g_q == GW'(ROUNDS - 1)) begin
                    state_d = DRAIN;
                end else begin
                    g_d = g_q + GW'(1);
                end
            end
            DRAIN: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.r0   = r0_q;
    assign bus.r1   = r1_q;
endmodule

// File: tb/tb_inner_loop_cs_param.sv
// Bench for inner_loop_cs_param: three configurations (ROUNDS=3, 1, 48) share stimulus and
// are checked every cycle against an arithmetic model of latency and r0+r1.
module tb_inner_loop_cs_param;
    localparam int unsigned LIMB_W    = 64;
    localparam int unsigned NUM_LIMBS = 48;
    localparam int unsigned EXT_W     = 2;
    localparam int unsigned NW        = NUM_LIMBS * LIMB_W;
    localparam int unsigned AW        = NW + EXT_W;
    localparam int unsigned RW        = NW + LIMB_W + EXT_W;
    localparam int unsigned RWW       = 32 * ((RW + 31) / 32);
    localparam int unsigned NI        = 3;
    localparam int unsigned ROUNDS_V [NI] = '{3, 1, 48};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start_in;
    logic [AW-1:0]     a_in;
    logic [LIMB_W-1:0] bi_in;
    logic [NW-1:0]     acc_in;
    int                tag_in;

    always #5 clk = ~clk;

    inner_loop_cs_param_if #(.LIMB_W(LIMB_W), .NUM_LIMBS(NUM_LIMBS), .EXT_W(EXT_W)) bus0 ();
    inner_loop_cs_param_if #(.LIMB_W(LIMB_W), .NUM_LIMBS(NUM_LIMBS), .EXT_W(EXT_W)) bus1 ();
    inner_loop_cs_param_if #(.LIMB_W(LIMB_W), .NUM_LIMBS(NUM_LIMBS), .EXT_W(EXT_W)) bus2 ();

    assign bus0.start = start_in;
    assign bus0.a     = a_in;
    assign bus0.bi    = bi_in;
    assign bus1.start = start_in;
    assign bus1.a     = a_in;
    assign bus1.bi    = bi_in;
    assign bus2.start = start_in;
    assign bus2.a     = a_in;
    assign bus2.bi    = bi_in;
`ifdef INNER_LOOP_ACC_EN
    assign bus0.acc = acc_in;
    assign bus1.acc = acc_in;
    assign bus2.acc = acc_in;
`endif

    inner_loop_cs_param #(.LIMB_W(LIMB_W), .NUM_LIMBS(NUM_LIMBS), .LANES(16), .EXT_W(EXT_W))
        u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    inner_loop_cs_param #(.LIMB_W(LIMB_W), .NUM_LIMBS(NUM_LIMBS), .LANES(48), .EXT_W(EXT_W))
        u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    inner_loop_cs_param #(.LIMB_W(LIMB_W), .NUM_LIMBS(NUM_LIMBS), .LANES(1), .EXT_W(EXT_W))
        u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    // Model state per instance: busy window, done pulse, expected a*bi+acc once complete.
    logic          m_busy [NI];
    logic          m_done [NI];
    logic          m_have [NI];
    logic          m_clr  [NI];
    int            m_left [NI];
    int            m_tag  [NI];
    int            m_acyc [NI];
    int            n_acc  [NI];
    logic [RW-1:0] m_exp  [NI];
    int            cyc = 0;

    int            n_checks = 0;
    int            n_fails  = 0;
    logic          o_busy [NI];
    logic          o_done [NI];
    logic [RW-1:0] o_r0   [NI];
    logic [RW-1:0] o_r1   [NI];
    logic [RW-1:0] exp_r0, exp_r1;

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
            for (int i = 0; i < int'(NI); i++) begin
                if (!rst_n) begin
                    m_busy[i] = 1'b0; m_done[i] = 1'b0; m_have[i] = 1'b1; m_clr[i] = 1'b1;
                    m_left[i] = 0;    m_tag[i]  = 0;    m_acyc[i] = 0;    m_exp[i] = '0;
                    if (cyc == 1) n_acc[i] = 0;
                end else begin
                    m_done[i] = 1'b0;
                    if (m_busy[i]) begin
                        m_left[i] = m_left[i] - 1;
                        if (m_left[i] == 0) begin
                            m_busy[i] = 1'b0;
                            m_done[i] = 1'b1;
                            m_have[i] = 1'b1;
                        end
                    end else if (start_in) begin
                        m_busy[i] = 1'b1;
                        m_left[i] = int'(ROUNDS_V[i]) + 1;
                        m_exp[i]  = RW'(a_in) * RW'(bi_in) + RW'(acc_in);
                        m_have[i] = 1'b0;
                        m_clr[i]  = 1'b0;
                        m_tag[i]  = tag_in;
                        m_acyc[i] = cyc;
                        n_acc[i]  = n_acc[i] + 1;
                    end
                end
            end
        end
    end

    task automatic chk(input string nm, input int inst, input logic [RW-1:0] act,
                       input logic [RW-1:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s dut%0d @cyc %0d: got low64=%h expected low64=%h upper_differs=%0b",
                     nm, inst, cyc, act[63:0], exp[63:0], act[RW-1:64] !== exp[RW-1:64]);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            o_busy[0] = bus0.busy; o_done[0] = bus0.done; o_r0[0] = bus0.r0; o_r1[0] = bus0.r1;
            o_busy[1] = bus1.busy; o_done[1] = bus1.done; o_r0[1] = bus1.r0; o_r1[1] = bus1.r1;
            o_busy[2] = bus2.busy; o_done[2] = bus2.done; o_r0[2] = bus2.r0; o_r1[2] = bus2.r1;
            for (int i = 0; i < int'(NI); i++) begin
                chk("busy", i, RW'(o_busy[i]), RW'(m_busy[i]));
                chk("done", i, RW'(o_done[i]), RW'(m_done[i]));
                if (m_have[i]) begin
                    chk("sum", i, o_r0[i] + o_r1[i], m_exp[i]);
                    chk("r1_limb0", i, RW'(o_r1[i][LIMB_W-1:0]), '0);
                    chk("r1_top", i, RW'(o_r1[i][RW-1 -: EXT_W]), '0);
                end
                if (m_clr[i]) begin
                    chk("r0_clear", i, o_r0[i], '0);
                    chk("r1_clear", i, o_r1[i], '0);
                end
            end
            // Hand-computed results for directed operations on the default configuration.
            if (m_done[0]) begin
                case (m_tag[0])
                    1: begin
                        chk("t1_r0", 0, o_r0[0], RW'(1));
                        chk("t1_r1", 0, o_r1[0], '0);
                        chk("t1_latency", 0, RW'(cyc - m_acyc[0]), RW'(4));
                    end
                    2: begin
                        exp_r0 = '0;
                        exp_r1 = '0;
                        for (int k = 0; k < int'(NUM_LIMBS); k++) begin
                            exp_r0 = exp_r0 | (RW'(64'h1) << (k * int'(LIMB_W)));
                            exp_r1 = exp_r1 | (RW'(64'hFFFF_FFFF_FFFF_FFFE) << ((k + 1) * int'(LIMB_W)));
                        end
                        chk("t2_r0", 0, o_r0[0], exp_r0);
                        chk("t2_r1", 0, o_r1[0], exp_r1);
                    end
                    3: begin
                        exp_r0 = RW'(66'h2_FFFF_FFFF_FFFF_FFFD) << NW;
                        chk("t3_r0", 0, o_r0[0], exp_r0);
                        chk("t3_r1", 0, o_r1[0], '0);
                    end
                    4: chk("t4_latency", 0, RW'(cyc - m_acyc[0]), RW'(4));
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [RWW-1:0] rand_wide();
        logic [RWW-1:0] t = '0;
        for (int w = 0; w < int'(RWW / 32); w++) begin
            t = {t[RWW-33:0], ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'($urandom)};
        end
        return t;
    endfunction

    function automatic logic [LIMB_W-1:0] rand_bi();
        if ($urandom_range(9) == 0) return '1;
        return {32'($urandom), 32'($urandom)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            tick();
            if (!m_busy[0] && !m_busy[1] && !m_busy[2]) break;
        end
    endtask

    task automatic run_op(input int tag, input logic [AW-1:0] a, input logic [LIMB_W-1:0] bi);
        start_in = 1'b1;
        a_in     = a;
        bi_in    = bi;
        acc_in   = '0;
        tag_in   = tag;
        tick();
        start_in = 1'b0;
        a_in     = AW'(rand_wide());
        bi_in    = rand_bi();
        tag_in   = 0;
        wait_idle();
    endtask

    initial begin
        logic [AW-1:0] av;
        int            base;
        rst_n    = 1'b0;
        start_in = 1'b0;
        a_in     = '0;
        bi_in    = '0;
        acc_in   = '0;
        tag_in   = 0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();

        run_op(1, AW'(1), LIMB_W'(1));
        av = '0;
        av[NW-1:0] = '1;
        run_op(2, av, '1);
        av = '0;
        av[AW-1 -: EXT_W] = '1;
        run_op(3, av, '1);

        // start held for three cycles, then a restart in the done cycle with inputs changing after.
        start_in = 1'b1;
        a_in     = AW'(rand_wide());
        bi_in    = rand_bi();
        tick();
        a_in  = AW'(rand_wide());
        bi_in = rand_bi();
        repeat (2) tick();
        start_in = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (m_done[0]) break;
            tick();
        end
        start_in = 1'b1;
        tag_in   = 4;
        a_in     = AW'(rand_wide());
        bi_in    = rand_bi();
        tick();
        start_in = 1'b0;
        tag_in   = 0;
        a_in     = AW'(rand_wide());
        bi_in    = rand_bi();
        wait_idle();

        // Reset during cycle 2 of an operation, then a clean operation.
        start_in = 1'b1;
        a_in     = AW'(rand_wide());
        bi_in    = rand_bi();
        tick();
        start_in = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        run_op(0, AW'(rand_wide()), rand_bi());

        // Continuous random requests: each instance accepts whenever it is free.
        base     = n_acc[2];
        start_in = 1'b1;
        for (int c = 0; c < 30000; c++) begin
            a_in  = AW'(rand_wide());
            bi_in = rand_bi();
`ifdef INNER_LOOP_ACC_EN
            acc_in = NW'(rand_wide());
`endif
            tick();
            if (n_acc[2] >= base + 500) break;
        end
        start_in = 1'b0;
        acc_in   = '0;
        wait_idle();
        repeat (2) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end
endmodule
